// File: rtl/cam_pixel_packer_if.sv
// Bundles the camera byte stream, the write-buffer port and the interrupt/status
// outputs of cam_pixel_packer.
//   master : the packer side (consumes camera bytes, drives the write buffer)
//   slave  : the environment side (camera source, buffer and IRQ logic)
interface cam_pixel_packer_if #(
    parameter int ADDR_W = 11
);
    logic [7:0]        din;
    logic              href;
    logic              vsync;
    logic              test_mode;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [15:0]       wr_data;
    logic              line_int;
    logic              line_bank;
    logic              frame_int;
    logic [9:0]        line_count;
    logic              ovf;

    modport master (
        input  din, href, vsync, test_mode,
        output wr_en, wr_addr, wr_data, line_int, line_bank, frame_int, line_count, ovf
    );

    modport slave (
        output din, href, vsync, test_mode,
        input  wr_en, wr_addr, wr_data, line_int, line_bank, frame_int, line_count, ovf
    );
endinterface

// File: rtl/cam_pixel_packer.sv
// cam_pixel_packer: packs pairs of camera bytes into RGB565 words and writes them
// into a two-line ping-pong region of the write buffer. It also raises one-cycle
// line and frame interrupts.
// Optional feature macro: CAM_TEST_PATTERN_EN. When it is defined and test_mode is
// high, wr_data carries {line_count[4:0], word index[10:0]} in place of camera data.
module cam_pixel_packer #(
    parameter int LINE_WORDS = 640,
    parameter int ADDR_W     = 11,
    parameter int HI_FIRST   = 1
) (
    input logic               clk,
    input logic               reset,
    cam_pixel_packer_if.master bus
);

    typedef enum logic [2:0] {
        WAIT_FRAME,
        WAIT_VS_LOW,
        IDLE,
        CAPTURE,
        LINE_END
    } state_t;

    localparam logic [ADDR_W-1:0] LINE_WORDS_A = ADDR_W'(LINE_WORDS);

    state_t            state;
    state_t            state_next;

    logic [7:0]        din_r;
    logic              href_r;
    logic              vsync_r;
    logic              vsync_d;

    logic              phase;
    logic [7:0]        first_byte;
    logic [ADDR_W-1:0] word_idx;
    logic              bank;

    logic              vsync_rise;
    logic              vsync_fall;
    logic              frame_edge;
    logic              take_byte;
    logic              room;
    logic              line_done;
    logic [15:0]       packed_word;
    logic [15:0]       pixel;
    logic [ADDR_W-1:0] base;

    // Register the raw camera inputs once and keep the previous vsync for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            din_r   <= '0;
            href_r  <= 1'b0;
            vsync_r <= 1'b0;
            vsync_d <= 1'b0;
        end else begin
            din_r   <= bus.din;
            href_r  <= bus.href;
            vsync_r <= bus.vsync;
            vsync_d <= vsync_r;
        end
    end

    // Decode edges and per-cycle actions from the registered inputs.
    always_comb begin
        vsync_rise  = vsync_r & ~vsync_d;
        vsync_fall  = ~vsync_r & vsync_d;
        frame_edge  = vsync_rise && (state != WAIT_FRAME);
        take_byte   = href_r && ((state == IDLE) || (state == CAPTURE)) && !frame_edge;
        room        = (word_idx < LINE_WORDS_A);
        line_done   = (state == LINE_END) && !frame_edge;
        packed_word = (HI_FIRST != 0) ? {first_byte, din_r} : {din_r, first_byte};
        base        = bank ? LINE_WORDS_A : '0;
`ifdef CAM_TEST_PATTERN_EN
        pixel       = bus.test_mode ? {bus.line_count[4:0], 11'(word_idx)} : packed_word;
`else
        pixel       = packed_word;
`endif
    end

`ifndef CAM_TEST_PATTERN_EN
    logic test_mode_unused;
    assign test_mode_unused = bus.test_mode;
`endif

    // Capture state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= WAIT_FRAME;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a vsync rise overrides everything, including a line end.
    always_comb begin
        state_next = state;
        if (vsync_rise) begin
            state_next = WAIT_VS_LOW;
        end else begin
            case (state)
                WAIT_FRAME:  state_next = WAIT_FRAME;
                WAIT_VS_LOW: if (vsync_fall) state_next = IDLE;
                IDLE:        if (href_r) state_next = CAPTURE;
                CAPTURE:     if (!href_r) state_next = LINE_END;
                LINE_END:    state_next = IDLE;
                default:     state_next = WAIT_FRAME;
            endcase
        end
    end

    // Byte packing, write generation, line/frame bookkeeping and interrupts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase          <= 1'b0;
            first_byte     <= '0;
            word_idx       <= '0;
            bank           <= 1'b0;
            bus.wr_en      <= 1'b0;
            bus.wr_addr    <= '0;
            bus.wr_data    <= '0;
            bus.line_int   <= 1'b0;
            bus.line_bank  <= 1'b0;
            bus.frame_int  <= 1'b0;
            bus.line_count <= '0;
            bus.ovf        <= 1'b0;
        end else begin
            bus.wr_en     <= 1'b0;
            bus.line_int  <= 1'b0;
            bus.frame_int <= 1'b0;
            if (frame_edge) begin
                bus.frame_int  <= 1'b1;
                bus.line_count <= '0;
                bus.ovf        <= 1'b0;
                phase          <= 1'b0;
                word_idx       <= '0;
                bank           <= 1'b0;
            end else begin
                if (take_byte) begin
                    phase <= ~phase;
                    if (!phase) begin
                        first_byte <= din_r;
                    end else if (room) begin
                        bus.wr_en   <= 1'b1;
                        bus.wr_addr <= base + word_idx;
                        bus.wr_data <= pixel;
                        word_idx    <= word_idx + 1'b1;
                    end else begin
                        bus.ovf <= 1'b1;
                    end
                end
                if (line_done) begin
                    bus.line_int  <= 1'b1;
                    bus.line_bank <= bank;
                    if (bus.line_count != 10'd1023) begin
                        bus.line_count <= bus.line_count + 10'd1;
                    end
                    bank     <= ~bank;
                    word_idx <= '0;
                    phase    <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_cam_pixel_packer.sv
// Self-checking bench for cam_pixel_packer: a table of camera lines with
// hand-computed write counts, addresses and status, plus hand-written sequences
// for frame sync, mid-line vsync, write latency and asynchronous reset.
module tb_cam_pixel_packer;

    localparam int LW = 640;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    cam_pixel_packer_if #(.ADDR_W(11)) bus ();

    cam_pixel_packer #(
        .LINE_WORDS(LW),
        .ADDR_W(11),
        .HI_FIRST(1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    typedef struct {
        logic [10:0] addr;
        logic [15:0] data;
    } exp_t;

    typedef struct {
        int nbytes;
        int start;
        bit tm;
        int writes;
        int first_addr;
        int bank;
        int count;
        bit ovf;
    } vec_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int checks = 0;
    int passed = 0;

    int cyc = 0;
    int wr_seen, wr_err, line_pulses, frame_pulses, last_bank;
    int first_addr, first_data, second_data;
    int first_wr_cyc, last_wr_cyc, line_cyc, last_drive_cyc;

    int  m_bank  = 0;
    int  m_lines = 0;
    bit  m_ovf   = 0;
    bit  m_armed = 0;

    // Observe the DUT 1 time unit after each rising edge and score writes against the model.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (bus.wr_en === 1'b1) begin
            if (wr_seen == 0) begin
                first_addr   = int'(bus.wr_addr);
                first_data   = int'(bus.wr_data);
                first_wr_cyc = cyc;
            end
            if (wr_seen == 1) second_data = int'(bus.wr_data);
            wr_seen++;
            last_wr_cyc = cyc;
            if (exp_q.size() == 0) begin
                wr_err++;
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.addr !== bus.wr_addr || mon_e.data !== bus.wr_data) wr_err++;
            end
        end
        if (bus.line_int === 1'b1) begin
            line_pulses++;
            last_bank = int'(bus.line_bank);
            line_cyc  = cyc;
        end
        if (bus.frame_int === 1'b1) frame_pulses++;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit expired, got timeout, expected finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check_output(input string name, input longint actual, input longint expected);
        checks++;
        if (actual == expected) passed++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    task automatic clear_monitor();
        wr_seen      = 0;
        wr_err       = 0;
        line_pulses  = 0;
        frame_pulses = 0;
        last_bank    = -1;
        first_addr   = -1;
        first_data   = -1;
        second_data  = -1;
        first_wr_cyc = -1;
        last_wr_cyc  = -1;
        line_cyc     = -1;
    endtask

    // Drive one href line; the model queues the expected words. A vsync rise is
    // injected at byte abort_at (or never when abort_at < 0).
    task automatic apply_stimulus(input int nbytes, input int start, input bit tm,
                                  input bit armed, input int abort_at);
        int          idx;
        bit          aborted;
        logic [7:0]  b;
        logic [7:0]  first;
        logic [15:0] w;
        exp_t        e;
        idx     = 0;
        aborted = 0;
        first   = '0;
        for (int i = 0; i < nbytes; i++) begin
            @(negedge clk);
            b = 8'(start + i);
            if (i == abort_at) begin
                bus.vsync = 1'b1;
                aborted   = 1;
            end
            bus.href      = 1'b1;
            bus.din       = b;
            bus.test_mode = tm;
            last_drive_cyc = cyc;
            if (armed && !aborted) begin
                if (i % 2 == 0) begin
                    first = b;
                end else if (idx < LW) begin
`ifdef CAM_TEST_PATTERN_EN
                    w = tm ? {5'(m_lines), 11'(idx)} : {first, b};
`else
                    w = {first, b};
`endif
                    e.addr = 11'(m_bank * LW + idx);
                    e.data = w;
                    exp_q.push_back(e);
                    idx++;
                end else begin
                    m_ovf = 1;
                end
            end
        end
        @(negedge clk);
        bus.href      = 1'b0;
        bus.test_mode = 1'b0;
        if (aborted) begin
            m_bank  = 0;
            m_lines = 0;
            m_ovf   = 0;
        end else if (armed) begin
            m_bank = m_bank ^ 1;
            if (m_lines < 1023) m_lines++;
        end
        repeat (8) @(negedge clk);
        if (aborted) begin
            bus.vsync = 1'b0;
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic pulse_vsync();
        @(negedge clk);
        bus.vsync = 1'b1;
        repeat (4) @(negedge clk);
        bus.vsync = 1'b0;
        repeat (4) @(negedge clk);
        m_bank  = 0;
        m_lines = 0;
        m_ovf   = 0;
        m_armed = 1;
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{1280, 'h00, 1'b0, 640,   0, 0, 1, 1'b0};
        vecs[1] = '{1280, 'h40, 1'b0, 640, 640, 1, 2, 1'b0};
        vecs[2] = '{1280, 'h80, 1'b1, 640,   0, 0, 3, 1'b0};
        vecs[3] = '{   7, 'h10, 1'b0,   3, 640, 1, 4, 1'b0};
        vecs[4] = '{   4, 'h20, 1'b0,   2,   0, 0, 5, 1'b0};
        vecs[5] = '{1300, 'h00, 1'b0, 640, 640, 1, 6, 1'b1};
        vecs[6] = '{   1, 'h55, 1'b0,   0,  -1, 0, 7, 1'b1};

        reset         = 1'b1;
        bus.din       = '0;
        bus.href      = 1'b0;
        bus.vsync     = 1'b0;
        bus.test_mode = 1'b0;
        clear_monitor();
        repeat (3) @(negedge clk);
        check_output("reset_wr_en", bus.wr_en, 0);
        check_output("reset_line_int", bus.line_int, 0);
        check_output("reset_frame_int", bus.frame_int, 0);
        check_output("reset_line_count", bus.line_count, 0);
        check_output("reset_ovf", bus.ovf, 0);
        check_output("reset_wr_addr", bus.wr_addr, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // href before any vsync is ignored
        clear_monitor();
        apply_stimulus(10, 'h30, 1'b0, 1'b0, -1);
        check_output("prevs_writes", wr_seen, 0);
        check_output("prevs_line_int", line_pulses, 0);

        // first vsync leaves WAIT_FRAME without a frame interrupt
        clear_monitor();
        pulse_vsync();
        check_output("first_vs_frame_int", frame_pulses, 0);

        for (int v = 0; v < 7; v++) begin
            clear_monitor();
            apply_stimulus(vecs[v].nbytes, vecs[v].start, vecs[v].tm, 1'b1, -1);
            check_output($sformatf("v%0d_writes", v), wr_seen, vecs[v].writes);
            check_output($sformatf("v%0d_wr_err", v), wr_err, 0);
            check_output($sformatf("v%0d_leftover", v), exp_q.size(), 0);
            check_output($sformatf("v%0d_first_addr", v), first_addr, vecs[v].first_addr);
            check_output($sformatf("v%0d_line_int", v), line_pulses, 1);
            check_output($sformatf("v%0d_line_bank", v), last_bank, vecs[v].bank);
            check_output($sformatf("v%0d_line_count", v), bus.line_count, vecs[v].count);
            check_output($sformatf("v%0d_ovf", v), bus.ovf, vecs[v].ovf);
            if (v == 0) begin
                check_output("v0_word0", first_data, 'h0001);
                check_output("v0_word1", second_data, 'h0203);
            end
            exp_q.delete();
        end

        // frame edge clears overflow and line count
        clear_monitor();
        pulse_vsync();
        check_output("frame_int_pulse", frame_pulses, 1);
        check_output("frame_ovf_clear", bus.ovf, 0);
        check_output("frame_count_clear", bus.line_count, 0);

        // write latency and ordering against line_int
        clear_monitor();
        apply_stimulus(2, 'hA0, 1'b0, 1'b1, -1);
        check_output("lat_writes", wr_seen, 1);
        check_output("lat_wr_err", wr_err, 0);
        check_output("lat_first_data", first_data, 'hA0A1);
        check_output("lat_wr_delay", first_wr_cyc - last_drive_cyc, 2);
        check_output("lat_line_after_wr", line_cyc > last_wr_cyc, 1);

        // vsync rising mid-line abandons the line
        clear_monitor();
        apply_stimulus(60, 'h00, 1'b0, 1'b1, 40);
        check_output("abort_writes", wr_seen, 20);
        check_output("abort_wr_err", wr_err, 0);
        check_output("abort_line_int", line_pulses, 0);
        check_output("abort_frame_int", frame_pulses, 1);
        check_output("abort_line_count", bus.line_count, 0);
        exp_q.delete();

        clear_monitor();
        apply_stimulus(4, 'h60, 1'b0, 1'b1, -1);
        check_output("post_abort_first_addr", first_addr, 0);
        check_output("post_abort_wr_err", wr_err, 0);
        check_output("post_abort_line_count", bus.line_count, 1);
        exp_q.delete();

        // asynchronous reset in the middle of a line
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.href = 1'b1;
            bus.din  = 8'(i);
        end
        #2;
        reset = 1'b1;
        #1;
        check_output("areset_line_count", bus.line_count, 0);
        check_output("areset_wr_en", bus.wr_en, 0);
        check_output("areset_wr_addr", bus.wr_addr, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        m_bank  = 0;
        m_lines = 0;
        m_ovf   = 0;
        m_armed = 0;
        clear_monitor();
        apply_stimulus(10, 'h10, 1'b0, 1'b0, -1);
        check_output("areset_writes", wr_seen, 0);
        check_output("areset_line_int", line_pulses, 0);

        clear_monitor();
        pulse_vsync();
        check_output("areset_vs_frame_int", frame_pulses, 0);
        clear_monitor();
        apply_stimulus(4, 'h70, 1'b0, 1'b1, -1);
        check_output("areset_restart_writes", wr_seen, 2);
        check_output("areset_restart_addr", first_addr, 0);
        check_output("areset_restart_wr_err", wr_err, 0);
        check_output("areset_restart_count", bus.line_count, 1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
